day_6_parser: RTL and testbench
===============================

# day_6_parser

Upstream stage of the day-6 solver: consumes the raw puzzle text as an ASCII byte stream and produces one problem record per column (four operands plus operator). Each record carries the four row values and the operator bit in the encoding the day-6 compute stage consumes. The four numeric rows are buffered internally; records are emitted while the operator row streams in.

## Interface

- DATA_WIDTH, 16, width of each operand
- MAX_PROBLEMS, 1000, column capacity of each row buffer
- IDX_WIDTH, 16, width of out_idx and num_problems

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a new parse (ignored outside IDLE/DONE)
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid && in_ready
- in_data  in  8  ASCII byte
- in_last  in  1  marks final byte of the file
- out_valid  out  1  record valid
- out_ready  in  1  downstream accepts record when out_valid && out_ready
- out_val0..out_val3  out  DATA_WIDTH each  operands from rows 0..3 of this column
- out_op  out  1  0 = multiply ('*'), 1 = add ('+')
- out_idx  out  IDX_WIDTH  column index, 0-based
- out_last  out  1  last record of the file
- done  out  1  parse complete; held until start or rst
- err  out  1  sticky format error; cleared by start or rst
- num_problems  out  IDX_WIDTH  column count of row 0, valid when done

## Operation

- States: IDLE, NUM, OP, DONE. On rst, and on start from IDLE or DONE, clear row, col, accumulator, counts, err and done; start moves to NUM.
- Byte classes: '0'-'9' = digit; 0x20 = separator; 0x0A = end of line; 0x0D = ignored; anything else sets err and is otherwise ignored.
- NUM (rows 0..3):
  - Digit: acc = acc*10 + d. If the true value exceeds 2^DATA_WIDTH-1, set err; keep acc modulo 2^DATA_WIDTH.
  - Separator or end of line with a token pending: write acc to buf[row][col], col++, clear acc. Runs of separators are legal; leading separators are legal.
  - col reaching MAX_PROBLEMS: further tokens are dropped and err is set.
  - End of line: row 0 records count0 = col. For rows 1-3, col != count0 sets err. Then row++ and col = 0. After row 3, go to OP.
  - in_last in NUM: flush any pending token, set err, go to DONE.
- OP (row 4):
  - '*' or '+': if an operator was accepted with no separator since the last one (e.g. "**"), or col >= count0, set err and drop the byte.
  - Otherwise load outputs from buf[0..3][col] (combinational buffer read), out_op, out_idx = col, out_last = (col == count0-1); then col++.
  - Digits in OP set err.
  - End of line or in_last: if col != count0, set err. Go to DONE once no record is pending; if a record is still pending, hold it until accepted, then go to DONE.
- DONE: in_ready = 0, done = 1, num_problems = count0. Only start or rst leave this state.
- Records are always emitted in ascending out_idx order and are never duplicated or skipped, except for dropped error bytes.

## Timing

- Reset values: in_ready 0, out_valid 0, out_val0..3 0, out_op 0, out_idx 0, out_last 0, done 0, err 0, num_problems 0.
- in_ready is registered-state combinational:
  - 1 in NUM.
  - In OP: !out_valid || out_ready.
  - 0 in IDLE and DONE.
- Byte throughput is one per cycle. A token write and a digit update both take effect at the edge that accepts the byte.
- Record latency: out_valid rises the cycle after the operator byte is accepted. out_valid and all out_* fields are held stable until out_ready. Accept and reload in the same cycle is allowed, giving one record per cycle.
- done asserts the cycle after the final record handshake, or after end of line/in_last if no record is pending.
- A start that coincides with rst: rst wins. rst mid-parse aborts immediately and drops any pending record.

## Test plan

- Basic: start, then "1 22\n3 44\n5 66\n7 88\n* +\n" with out_ready=1 -> records (1,3,5,7,op0,idx0,last0) and (22,44,66,88,op1,idx1,last1); done=1, num_problems=2, err=0.
- Backpressure: same input with out_ready toggled 1-0-0-1 randomly -> identical records, out_* stable while stalled, in_ready=0 whenever out_valid && !out_ready.
- Overflow and bad byte: row 0 "70000 5\n" -> err=1, out_val0 of idx0 = 4464. Separately, an 'x' in row 2 -> err=1 and parse continues.
- Count mismatch: row 1 has 3 tokens vs 2 in row 0 -> err=1. Operator row "*" only -> err=1 and done still asserts after the single record.
- Whitespace and CR: "  1   22 \r\n" style rows -> same values as the basic case, err=0.
- Reset/restart: rst asserted mid-row-2 -> all outputs at reset values the next cycle. A start after done with a new file -> num_problems and records reflect only the new file.

Source files
------------

// File: rtl/day_6_parser.sv
`default_nettype none
// ============================================================================
// Module   : day_6_parser
// Purpose  : Streams day-6 puzzle text, buffers four numeric rows and emits
//            one operand/operator record per column while the operator row
//            streams in.
// Revision : 1.0 - initial release
// ============================================================================
module day_6_parser #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_PROBLEMS = 1000,
  parameter int IDX_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_val0,
  output logic [DATA_WIDTH-1:0] out_val1,
  output logic [DATA_WIDTH-1:0] out_val2,
  output logic [DATA_WIDTH-1:0] out_val3,
  output logic                  out_op,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_last,
  output logic                  done,
  output logic                  err,
  output logic [IDX_WIDTH-1:0]  num_problems
);

  localparam int                    c_AW  = (MAX_PROBLEMS > 1) ? $clog2(MAX_PROBLEMS) : 1;
  localparam logic [IDX_WIDTH-1:0]  c_MAX = IDX_WIDTH'(MAX_PROBLEMS);
  localparam logic [DATA_WIDTH+3:0] c_TEN = (DATA_WIDTH+4)'(10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [1:0]            row_q;
  logic [IDX_WIDTH-1:0]  col_q;
  logic [IDX_WIDTH-1:0]  count0_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  pend_q;
  logic                  sep_ok_q;
  logic                  end_seen_q;
  logic                  err_q;
  logic                  done_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_val0_q;
  logic [DATA_WIDTH-1:0] out_val1_q;
  logic [DATA_WIDTH-1:0] out_val2_q;
  logic [DATA_WIDTH-1:0] out_val3_q;
  logic                  out_op_q;
  logic [IDX_WIDTH-1:0]  out_idx_q;
  logic                  out_last_q;

  logic [DATA_WIDTH-1:0] buf_q [4][MAX_PROBLEMS];

  logic                  w_in_ready;
  logic                  w_fire;
  logic                  w_is_digit;
  logic                  w_is_sep;
  logic                  w_is_eol;
  logic                  w_is_cr;
  logic                  w_is_mul;
  logic                  w_is_add;
  logic                  w_is_op;
  logic                  w_ends;
  logic [3:0]            w_digit;
  logic [DATA_WIDTH+3:0] w_acc_wide;
  logic                  w_acc_ovf;
  logic [DATA_WIDTH-1:0] acc_d;
  logic                  w_pend_d;
  logic                  w_flush;
  logic                  w_room;
  logic                  w_buf_we;
  logic                  w_op_ok;
  logic [IDX_WIDTH-1:0]  col_flush_d;
  logic [IDX_WIDTH-1:0]  col_op_d;
  logic [c_AW-1:0]       w_col_a;

  always_comb begin
    w_in_ready = 1'b0;
    case (state_q)
      S_NUM:   w_in_ready = 1'b1;
      S_OP:    w_in_ready = !end_seen_q && (!out_valid_q || out_ready);
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_fire     = in_valid && w_in_ready;
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign w_is_sep   = (in_data == 8'h20);
  assign w_is_eol   = (in_data == 8'h0A);
  assign w_is_cr    = (in_data == 8'h0D);
  assign w_is_mul   = (in_data == 8'h2A);
  assign w_is_add   = (in_data == 8'h2B);
  assign w_is_op    = w_is_mul || w_is_add;
  assign w_ends     = w_is_eol || in_last;
  assign w_digit    = in_data[3:0];

  // Widened by four bits so a carry out of the operand width flags overflow.
  assign w_acc_wide = ({4'd0, acc_q} * c_TEN) + {{DATA_WIDTH{1'b0}}, w_digit};
  assign w_acc_ovf  = |w_acc_wide[DATA_WIDTH+3:DATA_WIDTH];
  assign acc_d      = w_is_digit ? w_acc_wide[DATA_WIDTH-1:0] : acc_q;
  assign w_pend_d   = pend_q || w_is_digit;
  assign w_flush    = w_pend_d && (w_is_sep || w_is_eol || in_last);
  assign w_room     = (col_q < c_MAX);
  assign col_flush_d = col_q + IDX_WIDTH'(w_flush && w_room);
  assign w_col_a    = col_q[c_AW-1:0];
  assign w_buf_we   = !rst && w_fire && (state_q == S_NUM) && w_flush && w_room;

  assign w_op_ok    = w_is_op && sep_ok_q && (col_q < count0_q);
  assign col_op_d   = col_q + IDX_WIDTH'(w_op_ok);

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      buf_q[row_q][w_col_a] <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= 2'd0;
      col_q       <= '0;
      count0_q    <= '0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      sep_ok_q    <= 1'b0;
      end_seen_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_val0_q  <= '0;
      out_val1_q  <= '0;
      out_val2_q  <= '0;
      out_val3_q  <= '0;
      out_op_q    <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_NUM;
            row_q      <= 2'd0;
            col_q      <= '0;
            count0_q   <= '0;
            acc_q      <= '0;
            pend_q     <= 1'b0;
            sep_ok_q   <= 1'b0;
            end_seen_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
          end
        end

        S_NUM: begin
          if (w_fire) begin
            if (w_is_digit) begin
              acc_q  <= w_acc_wide[DATA_WIDTH-1:0];
              pend_q <= 1'b1;
              if (w_acc_ovf) err_q <= 1'b1;
            end else if (!(w_is_sep || w_is_eol || w_is_cr)) begin
              err_q <= 1'b1;
            end

            if (w_flush) begin
              acc_q  <= '0;
              pend_q <= 1'b0;
              col_q  <= col_flush_d;
              if (!w_room) err_q <= 1'b1;
            end

            // A file ending inside the numeric rows is always malformed.
            if (in_last) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (w_is_eol) begin
              if (row_q == 2'd0) begin
                count0_q <= col_flush_d;
              end else if (col_flush_d != count0_q) begin
                err_q <= 1'b1;
              end
              col_q <= '0;
              row_q <= row_q + 2'd1;
              if (row_q == 2'd3) begin
                state_q  <= S_OP;
                sep_ok_q <= 1'b1;
              end
            end
          end
        end

        S_OP: begin
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;

          if (w_fire) begin
            if (w_is_op) begin
              if (w_op_ok) begin
                out_valid_q <= 1'b1;
                out_val0_q  <= buf_q[0][w_col_a];
                out_val1_q  <= buf_q[1][w_col_a];
                out_val2_q  <= buf_q[2][w_col_a];
                out_val3_q  <= buf_q[3][w_col_a];
                out_op_q    <= w_is_add;
                out_idx_q   <= col_q;
                out_last_q  <= (col_q == count0_q - IDX_WIDTH'(1));
                col_q       <= col_op_d;
                sep_ok_q    <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end else if (w_is_sep) begin
              sep_ok_q <= 1'b1;
            end else if (!(w_is_eol || w_is_cr)) begin
              err_q <= 1'b1;
            end

            // An operator carrying in_last must drain its record before DONE.
            if (w_ends) begin
              if (col_op_d != count0_q) err_q <= 1'b1;
              if (w_op_ok) begin
                end_seen_q <= 1'b1;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end else if (end_seen_q && (!out_valid_q || out_ready)) begin
            end_seen_q <= 1'b0;
            state_q    <= S_DONE;
            done_q     <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = out_valid_q;
  assign out_val0     = out_val0_q;
  assign out_val1     = out_val1_q;
  assign out_val2     = out_val2_q;
  assign out_val3     = out_val3_q;
  assign out_op       = out_op_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign err          = err_q;
  assign num_problems = count0_q;

endmodule
`default_nettype wire

// File: tb/tb_day_6_parser.sv
`default_nettype none
// Testbench for day_6_parser: directed files plus randomized files checked
// against a line/token-level model of the puzzle format.
module tb_day_6_parser;

  localparam int DW   = 16;
  localparam int MAXP = 8;
  localparam int IW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_val0, out_val1, out_val2, out_val3;
  logic          out_op;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
  logic          err;
  logic [IW-1:0] num_problems;

  day_6_parser #(.DATA_WIDTH(DW), .MAX_PROBLEMS(MAXP), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val0(out_val0), .out_val1(out_val1), .out_val2(out_val2), .out_val3(out_val3),
    .out_op(out_op), .out_idx(out_idx), .out_last(out_last),
    .done(done), .err(err), .num_problems(num_problems)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v0, v1, v2, v3;
    logic        op;
    logic [15:0] idx;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  byte  fq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_err;
  int   exp_cnt;
  bit   bp_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic rec_t mk(input int a, input int b, input int c, input int d,
                              input bit op, input int idx, input bit last);
    rec_t r;
    r.v0 = 16'(a); r.v1 = 16'(b); r.v2 = 16'(c); r.v3 = 16'(d);
    r.op = op; r.idx = 16'(idx); r.last = last;
    return r;
  endfunction

  function automatic rec_t cur_rec();
    rec_t r;
    r.v0 = out_val0; r.v1 = out_val1; r.v2 = out_val2; r.v3 = out_val3;
    r.op = out_op; r.idx = out_idx; r.last = out_last;
    return r;
  endfunction

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Reference: tokenise the file line by line and pair columns with operators.
  task automatic model_file();
    int    vals [4][MAXP];
    int    nt [4];
    int    line, k, tm;
    longint tv;
    bit    pend, sep, stop, last;
    byte   c;
    exp_q.delete();
    exp_err = 0; exp_cnt = 0;
    line = 0; k = 0; tm = 0; tv = 0; pend = 0; sep = 1; stop = 0;
    for (int r = 0; r < 4; r++) nt[r] = 0;
    for (int i = 0; i < fq.size() && !stop; i++) begin
      c = fq[i];
      last = (i == fq.size() - 1);
      if (line < 4) begin
        if (c >= 8'h30 && c <= 8'h39) begin
          tv = tv * 10 + longint'(c - 8'h30);
          tm = (tm * 10 + int'(c - 8'h30)) % 65536;
          if (tv > 65535) begin exp_err = 1; tv = 65536; end
          pend = 1;
        end else if (c != 8'h20 && c != 8'h0A && c != 8'h0D) begin
          exp_err = 1;
        end
        if (pend && (c == 8'h20 || c == 8'h0A || last)) begin
          if (nt[line] < MAXP) begin vals[line][nt[line]] = tm; nt[line]++; end
          else exp_err = 1;
          pend = 0; tv = 0; tm = 0;
        end
        if (last) begin
          exp_err = 1; stop = 1;
        end else if (c == 8'h0A) begin
          if (line == 0) exp_cnt = nt[0];
          else if (nt[line] != exp_cnt) exp_err = 1;
          line++;
        end
      end else begin
        if (c == 8'h2A || c == 8'h2B) begin
          if (!sep || k >= exp_cnt) exp_err = 1;
          else begin
            exp_q.push_back(mk(vals[0][k], vals[1][k], vals[2][k], vals[3][k],
                               c == 8'h2B, k, k == exp_cnt - 1));
            k++; sep = 0;
          end
        end else if (c == 8'h20) sep = 1;
        else if (c != 8'h0D && c != 8'h0A) exp_err = 1;
        if (c == 8'h0A || last) begin
          if (k != exp_cnt) exp_err = 1;
          stop = 1;
        end
      end
    end
  endtask

  task automatic compare_loop();
    bit   stall_prev = 0;
    rec_t prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) check("held_record", cur_rec(), prev);
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
        if (done) check("in_ready_done", in_ready, 1'b0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_record: got idx %0d expected none", out_idx);
          end else begin
            check("record", cur_rec(), exp_q.pop_front());
          end
          got_q.push_back(cur_rec());
        end
        stall_prev = out_valid && !out_ready;
        prev = cur_rec();
      end
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    if ($urandom_range(0, 4) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_data = b; in_last = last; n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        n_checks++; n_fail++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 500 cycles");
        summary_and_finish();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_file(input bit bp);
    int n;
    model_file();
    got_q.delete();
    bp_mode = bp;
    do_start();
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i], i == fq.size() - 1);
    n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    check("done", done, 1'b1);
    check("err", err, exp_err);
    check("num_problems", num_problems, exp_cnt);
    check("records_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_vals", {out_val0, out_val1, out_val2, out_val3}, 64'd0);
    check("rst_op_idx_last", {out_op, out_idx, out_last}, 18'd0);
    check("rst_done_err", {done, err}, 2'd0);
    check("rst_num_problems", num_problems, 16'd0);
  endtask

  task automatic gen_random();
    int    ncol, cnt0, nt, nops, v;
    string s;
    fq.delete();
    ncol = $urandom_range(1, 9);
    cnt0 = (ncol > MAXP) ? MAXP : ncol;
    for (int r = 0; r < 4; r++) begin
      nt = ncol + ((r > 0 && $urandom_range(0, 9) == 0) ? 1 : 0);
      repeat ($urandom_range(0, 2)) fq.push_back(8'h20);
      for (int t = 0; t < nt; t++) begin
        v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99999) : $urandom_range(0, 9999);
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) begin
          fq.push_back(s[i]);
          if (i == 0 && $urandom_range(0, 24) == 0) fq.push_back(8'h78);
        end
        repeat ((t == nt - 1) ? $urandom_range(0, 1) : $urandom_range(1, 3)) fq.push_back(8'h20);
      end
      if ($urandom_range(0, 3) == 0) fq.push_back(8'h0D);
      fq.push_back(8'h0A);
    end
    case ($urandom_range(0, 7))
      0:       nops = cnt0 - 1;
      1:       nops = cnt0 + 1;
      default: nops = cnt0;
    endcase
    for (int o = 0; o < nops; o++) begin
      if (o > 0) repeat ($urandom_range(1, 2)) fq.push_back(8'h20);
      fq.push_back($urandom_range(0, 1) ? 8'h2B : 8'h2A);
      if ($urandom_range(0, 14) == 0) fq.push_back(8'h2A);
      if ($urandom_range(0, 29) == 0) fq.push_back(8'h37);
    end
    if (nops == 0 || $urandom_range(0, 4) != 0) fq.push_back(8'h0A);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    fork
      compare_loop();
      forever begin
        @(posedge clk); #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic file, no backpressure; literals pin both model and DUT.
    fq.delete(); add_str("1 22\n3 44\n5 66\n7 88\n* +\n");
    run_file(1'b0);
    check("basic_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("basic_rec0", got_q[0], mk(1, 3, 5, 7, 1'b0, 0, 1'b0));
      check("basic_rec1", got_q[1], mk(22, 44, 66, 88, 1'b1, 1, 1'b1));
    end
    check("basic_num", num_problems, 16'd2);
    check("basic_err", err, 1'b0);

    // Same file under random backpressure.
    run_file(1'b1);
    check("bp_count", got_q.size(), 2);
    if (got_q.size() >= 2) check("bp_rec1", got_q[1], mk(22, 44, 66, 88, 1'b1, 1, 1'b1));

    // Overflow wraps modulo 2^16.
    fq.delete(); add_str("70000 5\n1 2\n3 4\n5 6\n+ *\n");
    run_file(1'b0);
    check("ovf_err", err, 1'b1);
    if (got_q.size() >= 1) check("ovf_val0", got_q[0].v0, 16'd4464);

    // Bad byte in row 2 is ignored apart from err.
    fq.delete(); add_str("1 22\n3 44\n5x 66\n7 88\n* +\n");
    run_file(1'b1);
    check("badbyte_err", err, 1'b1);

    // Row count mismatch, then a short operator row.
    fq.delete(); add_str("1 22\n3 44 9\n5 66\n7 88\n* +\n");
    run_file(1'b0);
    fq.delete(); add_str("1 22\n3 44\n5 66\n7 88\n*\n");
    run_file(1'b1);
    check("shortop_err", err, 1'b1);
    check("shortop_count", got_q.size(), 1);

    // Whitespace runs and CR.
    fq.delete(); add_str("  1   22 \r\n3  44\r\n 5 66\r\n7    88 \r\n* +\r\n");
    run_file(1'b0);
    check("ws_err", err, 1'b0);

    // Capacity boundary, doubled operator, operator row without newline.
    fq.delete();
    for (int r = 0; r < 4; r++) add_str("1 2 3 4 5 6 7 8 9\n");
    add_str("+ + + + + + + *\n");
    run_file(1'b1);
    check("cap_num", num_problems, 16'd8);
    fq.delete(); add_str("1 22\n3 44\n5 66\n7 88\n** +\n");
    run_file(1'b0);
    fq.delete(); add_str("1 22\n3 44\n5 66\n7 88\n* +");
    run_file(1'b1);

    // Reset in the middle of row 2.
    fq.delete(); add_str("1 22\n3 44\n5 6");
    exp_q.delete();
    bp_mode = 1'b0;
    do_start();
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int f = 0; f < 30; f++) begin
      gen_random();
      run_file(1'($urandom_range(0, 1)));
    end

    summary_and_finish();
  end

  initial begin
    #800000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary_and_finish();
  end

endmodule
`default_nettype wire
